// File: rtl/alu_mdu_control_if.sv
// alu_mdu_control_if
//   Groups the EX-stage decode inputs and the MDU/ALU-control outputs of
//   alu_mdu_control into one bundle.
//   master : the EX-stage driver (supplies instruction fields and operands)
//   slave  : alu_mdu_control itself
//   Signals: valid_in, alu_op[1:0], function_field[5:0], operand_a/b[DATA_W],
//            alu_control[3:0], no_gpr_wb, stall, busy, hi/lo[DATA_W]
interface alu_mdu_control_if #(
  parameter int DATA_W = 32
);
  logic              valid_in;
  logic [1:0]        alu_op;
  logic [5:0]        function_field;
  logic [DATA_W-1:0] operand_a;
  logic [DATA_W-1:0] operand_b;
  logic [3:0]        alu_control;
  logic              no_gpr_wb;
  logic              stall;
  logic              busy;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output valid_in, alu_op, function_field, operand_a, operand_b,
    input  alu_control, no_gpr_wb, stall, busy, hi, lo
  );

  modport slave (
    input  valid_in, alu_op, function_field, operand_a, operand_b,
    output alu_control, no_gpr_wb, stall, busy, hi, lo
  );
endinterface

// File: rtl/alu_mdu_control.sv
// alu_mdu_control
//   EX-stage ALU control decoder plus a multi-cycle shift-add multiplier
//   (MULT/MULTU) with HI/LO registers and MFHI/MFLO interlock.
//   clk : single clock
//   rst : synchronous, active-high reset
//   bus : alu_mdu_control_if.slave (decode inputs, operands, ALU control,
//         no_gpr_wb, stall, busy, hi, lo)
module alu_mdu_control #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W)
) (
  input logic               clk,
  input logic               rst,
  alu_mdu_control_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_mcand;
  logic [2*DATA_W-1:0] r_prod;
  logic                r_neg;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;

  logic                w_rtype;
  logic                w_f_mult;
  logic                w_f_multu;
  logic                w_f_mfhi;
  logic                w_f_mflo;
  logic                w_mul_req;
  logic                w_mdu;
  logic                w_busy;
  logic                w_accept;
  logic [3:0]          w_alu_ctrl;
  logic [DATA_W-1:0]   w_mag_a;
  logic [DATA_W-1:0]   w_mag_b;
  logic [DATA_W:0]     w_sum;
  logic [2*DATA_W-1:0] w_prod_shift;
  logic [2*DATA_W-1:0] w_final;

  assign w_rtype   = (bus.alu_op == 2'd2);
  assign w_f_mult  = (bus.function_field == 6'b011000);
  assign w_f_multu = (bus.function_field == 6'b011001);
  assign w_f_mfhi  = (bus.function_field == 6'b010000);
  assign w_f_mflo  = (bus.function_field == 6'b010010);
  assign w_mul_req = bus.valid_in & w_rtype & (w_f_mult | w_f_multu);
  assign w_mdu     = bus.valid_in & w_rtype &
                     (w_f_mult | w_f_multu | w_f_mfhi | w_f_mflo);
  assign w_busy    = (r_state != S_IDLE);
  assign w_accept  = (r_state == S_IDLE) & w_mul_req;

  always_comb begin
    w_alu_ctrl = '0;
    unique case (bus.alu_op)
      2'd0: w_alu_ctrl = 4'd2;
      2'd1: w_alu_ctrl = 4'd5;
      2'd2: begin
        unique case (bus.function_field)
          6'b100000: w_alu_ctrl = 4'd2;
          6'b100010: w_alu_ctrl = 4'd5;
          6'b100100: w_alu_ctrl = 4'd0;
          6'b100101: w_alu_ctrl = 4'd1;
          6'b100111: w_alu_ctrl = 4'd12;
          6'b101010: w_alu_ctrl = 4'd7;
          6'b000000: w_alu_ctrl = 4'd3;
          6'b000010: w_alu_ctrl = 4'd4;
          6'b010000: w_alu_ctrl = 4'd8;
          6'b010010: w_alu_ctrl = 4'd9;
          6'b011000: w_alu_ctrl = 4'd2;
          6'b011001: w_alu_ctrl = 4'd2;
          default:   w_alu_ctrl = 4'd0;
        endcase
      end
      default: w_alu_ctrl = 4'd0;
    endcase
  end

  // Signed operands are multiplied as magnitudes; the sign is reapplied in FIX.
  // The magnitude of the most negative value still fits unsigned.
  assign w_mag_a = (w_f_mult & bus.operand_a[DATA_W-1]) ? -bus.operand_a : bus.operand_a;
  assign w_mag_b = (w_f_mult & bus.operand_b[DATA_W-1]) ? -bus.operand_b : bus.operand_b;

  // r_prod holds {accumulator upper half, remaining multiplier bits}; the
  // add carry becomes the new MSB as the whole chain shifts right.
  always_comb begin
    w_sum = {1'b0, r_prod[2*DATA_W-1:DATA_W]};
    if (r_prod[0]) begin
      w_sum = {1'b0, r_prod[2*DATA_W-1:DATA_W]} + {1'b0, r_mcand};
    end
    w_prod_shift = {w_sum, r_prod[DATA_W-1:1]};
  end

  assign w_final = r_neg ? -r_prod : r_prod;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_RUN;
      S_RUN:  if (r_cnt == CNT_W'(DATA_W - 1)) w_state_nxt = S_FIX;
      S_FIX:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_mcand <= '0;
      r_prod  <= '0;
      r_neg   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mcand <= w_mag_a;
            r_prod  <= {{DATA_W{1'b0}}, w_mag_b};
            r_neg   <= w_f_mult & (bus.operand_a[DATA_W-1] ^ bus.operand_b[DATA_W-1]);
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          r_prod <= w_prod_shift;
          r_cnt  <= r_cnt + CNT_W'(1);
        end
        S_FIX: begin
          r_hi <= w_final[2*DATA_W-1:DATA_W];
          r_lo <= w_final[DATA_W-1:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.alu_control = w_alu_ctrl;
  assign bus.no_gpr_wb   = w_mul_req;
  assign bus.stall       = w_busy & w_mdu;
  assign bus.busy        = w_busy;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;

endmodule

// File: doc/alu_mdu_control.md
# alu_mdu_control

Parametrised successor to the EX-stage ALU control decoder. It decodes `alu_op` and the R-type function field into the 4-bit ALU control code, and adds a multi-cycle shift-add multiply unit (MULT/MULTU) with HI/LO registers and MFHI/MFLO support. It sits in the EX stage beside the ALU and drives a stall to the hazard logic while a multiply is in flight.

## Interface

Parameters:
- `DATA_W`, default 32: operand width; HI and LO are each `DATA_W` bits.
- `CNT_W`, default `$clog2(DATA_W)`: width of the iteration counter.

Ports:
- `clk`, input, 1: the single clock.
- `rst`, input, 1: synchronous, active-high reset.
- `valid_in`, input, 1: the EX-stage instruction is valid (not a bubble).
- `alu_op`, input, 2: 0 = add, 1 = sub, 2 = R-type, 3 = reserved.
- `function_field`, input, 6: instruction bits [5:0].
- `operand_a`, input, `DATA_W`: rs value (multiplicand).
- `operand_b`, input, `DATA_W`: rt value (multiplier).
- `alu_control`, output, 4: ALU operation code.
- `no_gpr_wb`, output, 1: high for a valid MULT/MULTU; suppresses the register-file write.
- `stall`, output, 1: freeze IF/ID/EX this cycle.
- `busy`, output, 1: a multiply is in progress.
- `hi`, output, `DATA_W`: HI register.
- `lo`, output, `DATA_W`: LO register.

## Operation

Decode is combinational on `alu_op` and `function_field`.
- `alu_op` 0 gives 2 (ADD). `alu_op` 1 gives 5 (SUB). `alu_op` 3 gives 0.
- `alu_op` 2 decodes the function field:
  - 100000 gives 2; 100010 gives 5; 100100 gives 0; 100101 gives 1.
  - 100111 gives 12; 101010 gives 7; 000000 gives 3; 000010 gives 4.
  - MFHI (010000) gives 8; MFLO (010010) gives 9. The ALU result mux selects `hi` or `lo` for these codes.
  - MULT (011000) and MULTU (011001) give 2; the ALU result is unused.
  - Any other function field gives 0.
- An MDU instruction is `valid_in` and `alu_op`==2 and the function field is one of MULT, MULTU, MFHI, MFLO.

`stall` = `busy` AND (an MDU instruction is present). Non-MDU instructions never stall and proceed while a multiply runs.

FSM states are IDLE, RUN and FIX.
- IDLE:
  - A valid MULT/MULTU is accepted in this cycle (stall is 0).
  - The block latches the magnitudes of the operands (MULT: two's-complement absolute value; MULTU: raw).
  - It latches `neg` = sign(a) XOR sign(b) for MULT, and 0 for MULTU.
  - It clears the 2·`DATA_W` accumulator and the counter, then goes to RUN.
- RUN: one iteration per cycle.
  - If multiplier bit 0 is 1, the accumulator upper half is incremented by the multiplicand, with a carry into bit 2·`DATA_W`.
  - The {carry, accumulator, multiplier} chain shifts right by 1.
  - The counter increments. When counter = `DATA_W`-1, the next state is FIX.
- FIX:
  - If `neg`, the 2·`DATA_W` product is negated.
  - `hi` gets the upper half and `lo` gets the lower half, written on this edge. The next state is IDLE.

Other rules:
- `busy` = (state != IDLE).
- MFHI/MFLO in IDLE read `hi`/`lo` directly, with no stall.
- The magnitude of -2^(`DATA_W`-1) equals 2^(`DATA_W`-1), which fits in `DATA_W` unsigned bits; no overflow is possible.

## Timing

- Reset (synchronous): state = IDLE, counter = 0, `hi` = `lo` = 0, accumulator = 0. As a result `busy` = 0 and `stall` = 0.
- Reset mid-multiply wins over all other activity. The partial product is discarded and HI/LO are zeroed on that edge.
- MULT accepted in cycle 0:
  - RUN occupies cycles 1..`DATA_W`.
  - FIX is cycle `DATA_W`+1.
  - `hi`/`lo` hold the new value from cycle `DATA_W`+2.
  - `busy` is high in cycles 1..`DATA_W`+1. For `DATA_W`=32 that is cycles 1..33, with the result visible at cycle 34.
- `hi`/`lo` keep their old value throughout RUN/FIX.
- A second MULT or an MFHI/MFLO issued while busy stalls until the first IDLE cycle, then proceeds or is accepted in that same cycle.
- Operands are sampled only in the accept cycle. Later changes on `operand_a`/`operand_b` have no effect.
- `no_gpr_wb` and `alu_control` are purely combinational; they are valid in the same cycle and independent of stall.

## Test plan

- **Decode sweep.**
  - `alu_op`=2 with function 100000, 100010, 101010, 100111, 010000, 010010, 111111 gives `alu_control` 2, 5, 7, 12, 8, 9, 0.
  - `alu_op` 0 and 1 give 2 and 5.
  - MULT gives `no_gpr_wb`=1.
- **MULTU corner.** MULTU 0xFFFFFFFF × 0xFFFFFFFF at cycle 0 gives `busy` high in cycles 1..33, then `hi`=0xFFFFFFFE and `lo`=0x00000001 at cycle 34.
- **Signed MULT.**
  - -3 × 7 gives `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
  - 0x80000000 × 0x80000000 gives `hi`=0x40000000, `lo`=0x00000000.
  - 0x80000000 × 1 gives `hi`=0xFFFFFFFF, `lo`=0x80000000.
- **Hazard.**
  - MULT at cycle 0, then ADD at cycle 2: stall = 0.
  - MFLO held from cycle 3: stall = 1 in cycles 3..33 and 0 at cycle 34, with `alu_control`=9 and `lo` holding the new product.
- **Back-to-back.** MULTU 2×3, then MULTU 5×7 presented at cycle 1: the second stalls in cycles 1..33, is accepted at cycle 34, and gives `lo`=35 at cycle 68. The first result, `lo`=6, is visible in cycles 34..67.
- **Reset mid-operation.**
  - `rst` high in cycle 10 of a MULT gives `busy`=0, `stall`=0, `hi`=`lo`=0 at cycle 11.
  - A following MULTU 4×4 gives `lo`=16 after 34 cycles.
